// File: rtl/inst_fetch.sv
// Instruction fetch unit: owns the PC, fetches from a combinational instruction
// memory into a 2-entry FIFO toward decode, and resolves branch/jump redirects.
module inst_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0,
  parameter int unsigned IMEM_BYTES = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] read_address,
  input  logic [31:0] read_data,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  input  logic        branch_taken,
  input  logic [15:0] branch_offset,
  input  logic [31:0] branch_pc,
  input  logic        jump,
  input  logic [25:0] jump_target,
  output logic        fetch_err
);

  typedef enum logic {RUN, FAULT} state_t;

  localparam logic [31:0] LAST_PC = 32'(IMEM_BYTES - 4);

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] ent_pc_q [2];
  logic [31:0] ent_pc_d [2];
  logic [31:0] ent_inst_q [2];
  logic [31:0] ent_inst_d [2];

  logic [31:0] seq, br_tgt, j_tgt;
  logic        redirect, legal, pop, push;
  logic [1:0]  wr_slot;

  always_comb begin
    seq      = branch_pc + 32'd4;
    br_tgt   = seq + {{14{branch_offset[15]}}, branch_offset, 2'b00};
    j_tgt    = {seq[31:28], jump_target, 2'b00};
    redirect = jump | branch_taken;
    legal    = (pc_q[1:0] == 2'b00) && (pc_q <= LAST_PC);
    pop      = (cnt_q != 2'd0) && inst_ready;
    push     = (state_q == RUN) && !redirect && legal && ((cnt_q != 2'd2) || pop);
    wr_slot  = cnt_q - {1'b0, pop};

    state_d    = state_q;
    pc_d       = pc_q;
    cnt_d      = cnt_q;
    ent_pc_d   = ent_pc_q;
    ent_inst_d = ent_inst_q;

    if (redirect) begin
      pc_d    = jump ? j_tgt : br_tgt;
      cnt_d   = 2'd0;
      state_d = RUN;
    end else begin
      if ((state_q == RUN) && !legal) state_d = FAULT;
      // Head always lives in slot 0: a pop shifts slot 1 down, then a push
      // lands in the first free slot after that shift.
      if (pop) begin
        ent_pc_d[0]   = ent_pc_q[1];
        ent_inst_d[0] = ent_inst_q[1];
      end
      if (push) begin
        pc_d                   = pc_q + 32'd4;
        ent_pc_d[wr_slot[0]]   = pc_q;
        ent_inst_d[wr_slot[0]] = read_data;
      end
      cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      pc_q       <= RESET_PC;
      cnt_q      <= 2'd0;
      ent_pc_q   <= '{default: '0};
      ent_inst_q <= '{default: '0};
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      cnt_q      <= cnt_d;
      ent_pc_q   <= ent_pc_d;
      ent_inst_q <= ent_inst_d;
    end
  end

  assign read_address = pc_q;
  assign inst_valid   = (cnt_q != 2'd0);
  assign inst         = ent_inst_q[0];
  assign inst_pc      = ent_pc_q[0];
  assign fetch_err    = (state_q == FAULT);

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: big-endian memory model plus an expected-output
// queue checked whenever decode accepts an instruction.
`timescale 1ns/1ps
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] read_address, read_data;
  logic        inst_valid, inst_ready;
  logic [31:0] inst, inst_pc;
  logic        branch_taken, jump;
  logic [15:0] branch_offset;
  logic [31:0] branch_pc;
  logic [25:0] jump_target;
  logic        fetch_err;

  logic        rst2_n;
  logic [31:0] ra2, rd2, inst2, inst_pc2;
  logic        valid2, err2;

  logic [7:0]  mem [256];

  typedef struct {
    logic [31:0] pc;
    logic [31:0] w;
  } exp_t;
  exp_t sb [$];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign read_data = (read_address <= 32'd252) ?
    {mem[read_address[7:0]], mem[read_address[7:0] + 8'd1],
     mem[read_address[7:0] + 8'd2], mem[read_address[7:0] + 8'd3]} : 32'hDEAD_BEEF;
  assign rd2 = (ra2 <= 32'd252) ?
    {mem[ra2[7:0]], mem[ra2[7:0] + 8'd1], mem[ra2[7:0] + 8'd2], mem[ra2[7:0] + 8'd3]} : 32'hDEAD_BEEF;

  inst_fetch dut (
    .clk(clk), .rst_n(rst_n), .read_address(read_address), .read_data(read_data),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .inst_ready(inst_ready),
    .branch_taken(branch_taken), .branch_offset(branch_offset), .branch_pc(branch_pc),
    .jump(jump), .jump_target(jump_target), .fetch_err(fetch_err)
  );

  inst_fetch #(.RESET_PC(32'h2), .IMEM_BYTES(256)) dut2 (
    .clk(clk), .rst_n(rst2_n), .read_address(ra2), .read_data(rd2),
    .inst_valid(valid2), .inst(inst2), .inst_pc(inst_pc2), .inst_ready(1'b1),
    .branch_taken(1'b0), .branch_offset(16'h0), .branch_pc(32'h0),
    .jump(1'b0), .jump_target(26'h0), .fetch_err(err2)
  );

  function automatic logic [31:0] exp_word(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h8C08_0000;
      32'h4:   return 32'h8C09_0001;
      32'h8:   return 32'h0128_5024;
      default: return 32'h1000_0000 | a;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic expect_run(input logic [31:0] start, input int unsigned n);
    exp_t e;
    for (int unsigned i = 0; i < n; i++) begin
      e.pc = start + 32'(4 * i);
      e.w  = exp_word(e.pc);
      sb.push_back(e);
    end
  endtask

  // Compare the head against the queue on every cycle decode accepts it.
  task automatic mon();
    exp_t e;
    if (inst_valid && inst_ready && !(jump || branch_taken)) begin
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL sb_unexpected: observed pc %h expected no output", inst_pc);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("sb_pc", inst_pc, e.pc);
        chk("sb_inst", inst, e.w);
      end
    end
  endtask

  task automatic sample();
    @(negedge clk);
    mon();
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_redirect();
    branch_taken  = 1'b0;
    jump          = 1'b0;
    branch_offset = '0;
    branch_pc     = '0;
    jump_target   = '0;
  endtask

  initial begin
    for (int unsigned a = 0; a < 256; a += 4) begin
      logic [31:0] w;
      w = exp_word(32'(a));
      mem[a]   = w[31:24];
      mem[a+1] = w[23:16];
      mem[a+2] = w[15:8];
      mem[a+3] = w[7:0];
    end
    rst_n = 1'b0;
    rst2_n = 1'b0;
    inst_ready = 1'b1;
    clear_redirect();

    repeat (2) next();
    sample();
    chk("rst_ra", read_address, 32'h0);
    chk("rst_valid", {31'b0, inst_valid}, 32'h0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_inst_pc", inst_pc, 32'h0);
    chk("rst_err", {31'b0, fetch_err}, 32'h0);
    chk("rst2_ra", ra2, 32'h2);

    // Straight-line fetch
    next();
    rst_n = 1'b1;
    expect_run(32'h0, 8);
    sample();
    chk("s1_c1_ra", read_address, 32'h0);
    chk("s1_c1_valid", {31'b0, inst_valid}, 32'h0);
    next();
    sample();
    chk("s1_c2_ra", read_address, 32'h4);
    chk("s1_c2_valid", {31'b0, inst_valid}, 32'h1);
    next();
    sample();
    chk("s1_c3_ra", read_address, 32'h8);
    next();
    sample();
    chk("s1_c4_ra", read_address, 32'hC);
    next();
    inst_ready = 1'b0;
    sample();
    next();
    sample();
    chk("s1_full_pc", inst_pc, 32'hC);
    chk("s1_full_ra", read_address, 32'h14);
    next();
    sample();
    chk("s1_hold_ra", read_address, 32'h14);
    chk("s1_hold_pc", inst_pc, 32'hC);

    // Asynchronous reset with the buffer full
    #2 rst_n = 1'b0;
    #1;
    chk("s6_valid", {31'b0, inst_valid}, 32'h0);
    chk("s6_ra", read_address, 32'h0);
    chk("s6_inst_pc", inst_pc, 32'h0);
    sb.delete();
    next();
    next();

    // Backpressure after reset
    rst_n = 1'b1;
    expect_run(32'h0, 12);
    repeat (4) begin
      sample();
      next();
    end
    sample();
    chk("s2_ra", read_address, 32'h8);
    chk("s2_inst", inst, 32'h8C08_0000);
    chk("s2_inst_pc", inst_pc, 32'h0);
    chk("s2_valid", {31'b0, inst_valid}, 32'h1);
    next();
    inst_ready = 1'b1;
    repeat (4) begin
      sample();
      chk("s2_tput_valid", {31'b0, inst_valid}, 32'h1);
      next();
    end

    // Forward branch: 0x0C + 4 + (10 << 2) = 0x38
    branch_taken = 1'b1; branch_pc = 32'hC; branch_offset = 16'h000A;
    sample();
    next();
    clear_redirect();
    sb.delete();
    expect_run(32'h38, 2);
    sample();
    chk("s3f_valid", {31'b0, inst_valid}, 32'h0);
    chk("s3f_ra", read_address, 32'h38);
    next();
    sample();
    chk("s3f_inst_pc", inst_pc, 32'h38);
    next();

    // Backward branch: 0x28 + 4 - 16 = 0x1C
    branch_taken = 1'b1; branch_pc = 32'h28; branch_offset = 16'hFFFC;
    sample();
    next();
    clear_redirect();
    sb.delete();
    expect_run(32'h1C, 2);
    sample();
    chk("s3b_ra", read_address, 32'h1C);
    next();
    sample();
    chk("s3b_inst_pc", inst_pc, 32'h1C);
    next();

    // Branch and jump together: jump target 0x08 wins over branch target 0x60
    branch_taken = 1'b1; jump = 1'b1; branch_pc = 32'h34;
    branch_offset = 16'h000A; jump_target = 26'h2;
    sample();
    next();
    clear_redirect();
    sb.delete();
    expect_run(32'h8, 2);
    sample();
    chk("s3j_ra", read_address, 32'h8);
    next();
    sample();
    chk("s3j_inst_pc", inst_pc, 32'h8);
    chk("s3j_inst", inst, 32'h0128_5024);
    next();

    // Jump whose upper bits come from the carry into branch_pc + 4
    jump = 1'b1; branch_pc = 32'hEFFF_FFFC; jump_target = 26'h3;
    sample();
    next();
    clear_redirect();
    sb.delete();
    sample();
    chk("s4_ra", read_address, 32'hF000_000C);
    chk("s4_err_pre", {31'b0, fetch_err}, 32'h0);
    next();
    sample();
    chk("s4_err", {31'b0, fetch_err}, 32'h1);
    chk("s4_valid", {31'b0, inst_valid}, 32'h0);
    next();

    // Sequential run off the end of memory with entries buffered
    branch_taken = 1'b1; branch_pc = 32'hF0; branch_offset = 16'h0001; inst_ready = 1'b0;
    sample();
    next();
    clear_redirect();
    sample();
    chk("s5s_ra0", read_address, 32'hF8);
    chk("s5s_err_clr", {31'b0, fetch_err}, 32'h0);
    next();
    sample();
    chk("s5s_ra1", read_address, 32'hFC);
    chk("s5s_head", inst_pc, 32'hF8);
    next();
    sample();
    chk("s5s_ra2", read_address, 32'h100);
    chk("s5s_err_pre", {31'b0, fetch_err}, 32'h0);
    next();
    sample();
    chk("s5s_err", {31'b0, fetch_err}, 32'h1);
    chk("s5s_kept", {31'b0, inst_valid}, 32'h1);
    next();
    inst_ready = 1'b1;
    expect_run(32'hF8, 2);
    repeat (2) begin
      sample();
      next();
    end
    sample();
    chk("s5s_drained", {31'b0, inst_valid}, 32'h0);
    chk("s5s_err_hold", {31'b0, fetch_err}, 32'h1);
    chk("s5s_sb_empty", 32'(sb.size()), 32'h0);
    next();

    // Jump to 0x100
    jump = 1'b1; branch_pc = 32'h0; jump_target = 26'h40;
    sample();
    next();
    clear_redirect();
    sample();
    chk("s5j_ra", read_address, 32'h100);
    chk("s5j_err_pre", {31'b0, fetch_err}, 32'h0);
    next();
    sample();
    chk("s5j_err", {31'b0, fetch_err}, 32'h1);
    chk("s5j_valid", {31'b0, inst_valid}, 32'h0);
    next();

    // Recovery by branch whose target wraps to 0
    branch_taken = 1'b1; branch_pc = 32'hFFFF_FFFC; branch_offset = 16'h0;
    sample();
    next();
    clear_redirect();
    expect_run(32'h0, 4);
    sample();
    chk("s5r_err", {31'b0, fetch_err}, 32'h0);
    chk("s5r_ra", read_address, 32'h0);
    next();
    sample();
    chk("s5r_valid", {31'b0, inst_valid}, 32'h1);
    chk("s5r_inst_pc", inst_pc, 32'h0);
    next();
    inst_ready = 1'b0;
    sb.delete();

    // Misaligned reset PC
    rst2_n = 1'b1;
    sample();
    chk("s5m_ra", ra2, 32'h2);
    chk("s5m_err_pre", {31'b0, err2}, 32'h0);
    next();
    sample();
    chk("s5m_err", {31'b0, err2}, 32'h1);
    chk("s5m_valid", {31'b0, valid2}, 32'h0);
    next();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
